// File: rtl/lcd_frame_sink.sv
// lcd_frame_sink
//   Terminal stage of the LCD drive pipeline. Accepts the 2-pixel beat
//   stream, keeps per-frame statistics (beat count, checksum, done,
//   overflow), and buffers beats in a small FIFO. The CPU inspects the
//   statistics and drains the FIFO through a zero-wait AHB slave port.
module lcd_frame_sink #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int W_WB_DATA    = 2,
  parameter int IMG_PIX_W    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int W_FRAME_SIZE = 25,
  parameter int DEF_EXPECT   = 196608
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 sl_HSEL,
  input  logic                 sl_HREADY,
  input  logic [1:0]           sl_HTRANS,
  input  logic [W_ADDR-1:0]    sl_HADDR,
  input  logic                 sl_HWRITE,
  input  logic [W_DATA-1:0]    sl_HWDATA,
  output logic                 out_sl_HREADY,
  output logic [1:0]           out_sl_HRESP,
  output logic [W_DATA-1:0]    out_sl_HRDATA,
  input  logic                 in_valid,
  input  logic [IMG_PIX_W-1:0] in_r0,
  input  logic [IMG_PIX_W-1:0] in_g0,
  input  logic [IMG_PIX_W-1:0] in_b0,
  input  logic [IMG_PIX_W-1:0] in_r1,
  input  logic [IMG_PIX_W-1:0] in_g1,
  input  logic [IMG_PIX_W-1:0] in_b1,
  output logic                 frame_irq
);

  localparam int W_PTR  = $clog2(FIFO_DEPTH);
  localparam int W_LVL  = W_PTR + 1;
  localparam int W_PIX  = 3 * IMG_PIX_W;
  localparam int W_BEAT = 2 * W_PIX;
  localparam int N_CHAN = 6;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_EXPECT   = 4'd2;
  localparam logic [3:0] REG_BEAT_CNT = 4'd3;
  localparam logic [3:0] REG_CHECKSUM = 4'd4;
  localparam logic [3:0] REG_PIX0     = 4'd5;
  localparam logic [3:0] REG_PIX1     = 4'd6;

  localparam logic [1:0]       RESP_OKAY = 2'b00;
  localparam logic [W_LVL-1:0] LVL_FULL  = W_LVL'(FIFO_DEPTH);

  genvar gi;

  // --------------------------------------------------------------------
  // AHB slave pipeline
  // --------------------------------------------------------------------
  logic       addr_ok;
  logic       dph_valid_reg;
  logic       dph_write_reg;
  logic [3:0] dph_idx_reg;
  logic       dph_wr;
  logic       dph_rd;

  // Only NONSEQ/SEQ transfers are real; IDLE/BUSY never reach the data phase.
  assign addr_ok = sl_HSEL & sl_HREADY & sl_HTRANS[1];
  assign dph_wr  = dph_valid_reg & dph_write_reg;
  assign dph_rd  = dph_valid_reg & ~dph_write_reg;

  // The slave never stalls and never errors.
  assign out_sl_HREADY = 1'b1;
  assign out_sl_HRESP  = RESP_OKAY;

  // Address-phase capture: the access is performed in the following cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid_reg <= 1'b0;
      dph_write_reg <= 1'b0;
      dph_idx_reg   <= REG_CTRL;
    end else begin
      dph_valid_reg <= addr_ok;
      if (addr_ok) begin
        dph_write_reg <= sl_HWRITE;
        dph_idx_reg   <= sl_HADDR[W_WB_DATA+3:W_WB_DATA];
      end
    end
  end

  // Address byte-offset/upper bits, HTRANS[0] and upper HWDATA are don't-care.
  logic unused_bits;
  assign unused_bits = ^{sl_HTRANS[0], sl_HADDR, sl_HWDATA};

  // --------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------
  logic                    enable_reg;
  logic                    irq_en_reg;
  logic [W_FRAME_SIZE-1:0] expect_reg;
  logic                    clear_now;

  // Clear is a write-one pulse; it is never stored, so CTRL[1] reads 0.
  assign clear_now = dph_wr & (dph_idx_reg == REG_CTRL) & sl_HWDATA[1];

  // CTRL/EXPECT writes; clear does not touch enable, irq_en or EXPECT.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable_reg <= 1'b0;
      irq_en_reg <= 1'b0;
      expect_reg <= W_FRAME_SIZE'(DEF_EXPECT);
    end else if (dph_wr) begin
      if (dph_idx_reg == REG_CTRL) begin
        enable_reg <= sl_HWDATA[0];
        irq_en_reg <= sl_HWDATA[2];
      end
      if (dph_idx_reg == REG_EXPECT) begin
        expect_reg <= sl_HWDATA[W_FRAME_SIZE-1:0];
      end
    end
  end

  // --------------------------------------------------------------------
  // Beat input and per-beat channel sum
  // --------------------------------------------------------------------
  logic [IMG_PIX_W-1:0] chan [N_CHAN];
  logic [W_DATA-1:0]    chan_ext [N_CHAN];
  logic [W_DATA-1:0]    beat_sum;
  logic [W_BEAT-1:0]    beat_in;

  assign chan[0] = in_r0;
  assign chan[1] = in_g0;
  assign chan[2] = in_b0;
  assign chan[3] = in_r1;
  assign chan[4] = in_g1;
  assign chan[5] = in_b1;

  // Pixel 0 occupies the upper half of a stored beat, pixel 1 the lower.
  assign beat_in = {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1};

  generate
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
      assign chan_ext[gi] = W_DATA'(chan[gi]);
    end
  endgenerate

  // Checksum contribution of one beat: plain sum of all six channels.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      beat_sum = beat_sum + chan_ext[i];
    end
  end

  // --------------------------------------------------------------------
  // FIFO bookkeeping
  // --------------------------------------------------------------------
  logic [W_BEAT-1:0] fifo_mem [FIFO_DEPTH];
  logic [W_PTR-1:0]  wr_ptr_reg;
  logic [W_PTR-1:0]  rd_ptr_reg;
  logic [W_LVL-1:0]  level_reg;
  logic [W_LVL-1:0]  level_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic [W_BEAT-1:0] head_beat;

  logic                    frame_done_reg;
  logic                    overflow_reg;
  logic [W_FRAME_SIZE-1:0] beat_cnt_reg;
  logic [W_FRAME_SIZE-1:0] beat_cnt_next;
  logic [W_DATA-1:0]       checksum_reg;

  logic accept;
  logic pop;
  logic push;
  logic ovf_set;
  logic done_set;

  assign fifo_full  = (level_reg == LVL_FULL);
  assign fifo_empty = (level_reg == '0);

  // An empty FIFO presents zero so PIX0/PIX1 reads of nothing return 0.
  assign head_beat = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

  // Clear has priority over both the incoming beat and a same-cycle pop.
  assign accept   = in_valid & enable_reg & ~frame_done_reg & ~clear_now;
  assign pop      = dph_rd & (dph_idx_reg == REG_PIX1) & ~fifo_empty & ~clear_now;
  // A full FIFO can still take a beat if the head leaves in the same cycle.
  assign push     = accept & (~fifo_full | pop);
  assign ovf_set  = accept & fifo_full & ~pop;

  assign beat_cnt_next = beat_cnt_reg + 1'b1;
  // EXPECT == 0 means "no frame length", so done can never trigger.
  assign done_set = accept & (expect_reg != '0) & (beat_cnt_next == expect_reg);

  // Occupancy follows the push/pop pair; simultaneous push+pop keeps it.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Beat storage; validity is defined by the pointers, so no reset needed.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= beat_in;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear_now) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
    end
  end

  // Frame statistics; dropped beats are still counted and summed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_reg   <= '0;
      checksum_reg   <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (clear_now) begin
      beat_cnt_reg   <= '0;
      checksum_reg   <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt_reg <= beat_cnt_next;
        checksum_reg <= checksum_reg + beat_sum;
      end
      if (done_set) begin
        frame_done_reg <= 1'b1;
      end
      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign frame_irq = frame_done_reg & irq_en_reg;

  // --------------------------------------------------------------------
  // Read-back
  // --------------------------------------------------------------------
  logic [W_DATA-1:0] status_word;

  // STATUS layout: done, overflow, empty, full, level in [15:8].
  always_comb begin
    status_word       = '0;
    status_word[0]    = frame_done_reg;
    status_word[1]    = overflow_reg;
    status_word[2]    = fifo_empty;
    status_word[3]    = fifo_full;
    status_word[15:8] = 8'(level_reg);
  end

  // Data-phase read mux, driven from the latched register index.
  always_comb begin
    out_sl_HRDATA = '0;
    case (dph_idx_reg)
      REG_CTRL:     out_sl_HRDATA = W_DATA'({irq_en_reg, 1'b0, enable_reg});
      REG_STATUS:   out_sl_HRDATA = status_word;
      REG_EXPECT:   out_sl_HRDATA = W_DATA'(expect_reg);
      REG_BEAT_CNT: out_sl_HRDATA = W_DATA'(beat_cnt_reg);
      REG_CHECKSUM: out_sl_HRDATA = checksum_reg;
      REG_PIX0:     out_sl_HRDATA = W_DATA'(head_beat[W_BEAT-1:W_PIX]);
      REG_PIX1:     out_sl_HRDATA = W_DATA'(head_beat[W_PIX-1:0]);
      default:      out_sl_HRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_sink.sv
// tb_lcd_frame_sink: directed and randomized checks of lcd_frame_sink
// against a queue-based reference model of the frame sink.
`timescale 1ns/1ps
module tb_lcd_frame_sink;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        sl_HSEL = 1'b0;
  logic        sl_HREADY = 1'b1;
  logic [1:0]  sl_HTRANS = 2'b00;
  logic [31:0] sl_HADDR = 32'h0;
  logic        sl_HWRITE = 1'b0;
  logic [31:0] sl_HWDATA = 32'h0;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic        in_valid = 1'b0;
  logic [7:0]  in_r0 = 8'h0, in_g0 = 8'h0, in_b0 = 8'h0;
  logic [7:0]  in_r1 = 8'h0, in_g1 = 8'h0, in_b1 = 8'h0;
  logic        frame_irq;

  always #5 HCLK = ~HCLK;

  lcd_frame_sink dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .sl_HSEL       (sl_HSEL),
    .sl_HREADY     (sl_HREADY),
    .sl_HTRANS     (sl_HTRANS),
    .sl_HADDR      (sl_HADDR),
    .sl_HWRITE     (sl_HWRITE),
    .sl_HWDATA     (sl_HWDATA),
    .out_sl_HREADY (out_sl_HREADY),
    .out_sl_HRESP  (out_sl_HRESP),
    .out_sl_HRDATA (out_sl_HRDATA),
    .in_valid      (in_valid),
    .in_r0         (in_r0),
    .in_g0         (in_g0),
    .in_b0         (in_b0),
    .in_r1         (in_r1),
    .in_g1         (in_g1),
    .in_b1         (in_b1),
    .frame_irq     (frame_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame statistics plus the FIFO as a plain queue.
  bit          m_en, m_irq, m_done, m_ovf;
  logic [24:0] m_exp, m_cnt;
  logic [31:0] m_sum;
  logic [47:0] m_q [$];
  bit          m_dv, m_dw;
  logic [3:0]  m_di;

  function automatic void model_reset();
    m_en = 0; m_irq = 0; m_done = 0; m_ovf = 0;
    m_exp = 25'd196608; m_cnt = 0; m_sum = 0;
    m_q.delete();
    m_dv = 0; m_dw = 0; m_di = 0;
  endfunction

  function automatic logic [31:0] chsum(input logic [47:0] b);
    logic [31:0] s = 0;
    for (int k = 0; k < 6; k++) s += 32'(b[k*8 +: 8]);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    logic [47:0] h;
    logic [31:0] st;
    h = (m_q.size() > 0) ? m_q[0] : 48'h0;
    st = 32'h0;
    st[0] = m_done;
    st[1] = m_ovf;
    st[2] = (m_q.size() == 0);
    st[3] = (m_q.size() == 16);
    st[15:8] = 8'(m_q.size());
    case (idx)
      4'd0: return {29'h0, m_irq, 1'b0, m_en};
      4'd1: return st;
      4'd2: return {7'h0, m_exp};
      4'd3: return {7'h0, m_cnt};
      4'd4: return m_sum;
      4'd5: return {8'h0, h[47:24]};
      4'd6: return {8'h0, h[23:0]};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: new address phase (av/tr/aidx/awr), data for the pending
  // data phase (wdata), and an optional beat. Reads are checked here.
  task automatic cycle(input bit av, input logic [1:0] tr, input logic [3:0] aidx,
                       input bit awr, input logic [31:0] wdata, input bit bv,
                       input logic [47:0] beat, output logic [31:0] rdata);
    bit clr, pop, acc;
    logic [24:0] old_exp;
    @(negedge HCLK);
    chk("irq", frame_irq, m_done & m_irq);
    sl_HSEL   = av;
    sl_HTRANS = tr;
    sl_HADDR  = ($urandom() & 32'hFFFF_FFC3) | {26'h0, aidx, 2'b00};
    sl_HWRITE = awr;
    sl_HWDATA = wdata;
    in_valid  = bv;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = beat;
    #1;
    rdata = out_sl_HRDATA;
    if (m_dv) begin
      if (!m_dw) begin
        chk($sformatf("rd%0d", m_di), rdata, model_read(m_di));
        $display("[TB] t=%0t RD idx=%0d data=0x%08h", $time, m_di, rdata);
      end else begin
        $display("[TB] t=%0t WR idx=%0d data=0x%08h", $time, m_di, wdata);
      end
    end
    @(posedge HCLK);
    clr = m_dv & m_dw & (m_di == 4'd0) & wdata[1];
    pop = m_dv & !m_dw & (m_di == 4'd6) & (m_q.size() > 0) & !clr;
    acc = bv & m_en & !m_done & !clr;
    old_exp = m_exp;
    if (clr) begin
      m_cnt = 0; m_sum = 0; m_done = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_cnt = m_cnt + 1;
        m_sum = m_sum + chsum(beat);
        if (m_q.size() < 16) m_q.push_back(beat);
        else m_ovf = 1;
        if (old_exp != 0 && m_cnt == old_exp) m_done = 1;
      end
    end
    if (m_dv & m_dw) begin
      if (m_di == 4'd0) begin
        m_en  = wdata[0];
        m_irq = wdata[2];
      end
      if (m_di == 4'd2) m_exp = wdata[24:0];
    end
    m_dv = av & tr[1];
    if (av & tr[1]) begin
      m_di = aidx;
      m_dw = awr;
    end
  endtask

  task automatic idle(input bit bv = 0, input logic [47:0] beat = 48'h0);
    logic [31:0] d;
    cycle(0, 2'b00, 4'd0, 0, 32'h0, bv, beat, d);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] data,
                    input bit bv = 0, input logic [47:0] beat = 48'h0);
    logic [31:0] d;
    cycle(1, 2'b10, idx, 1, 32'h0, 0, 48'h0, d);
    cycle(0, 2'b00, 4'd0, 0, data, bv, beat, d);
  endtask

  task automatic rd(input logic [3:0] idx, output logic [31:0] data,
                    input bit bv = 0, input logic [47:0] beat = 48'h0);
    cycle(1, 2'b10, idx, 0, 32'h0, 0, 48'h0, data);
    cycle(0, 2'b00, 4'd0, 0, 32'h0, bv, beat, data);
  endtask

  function automatic logic [47:0] rnd_beat();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [47:0] b0, nb;
    bit          av, awr, bv;
    logic [1:0]  tr;
    logic [3:0]  aidx;
    logic [31:0] wd;
    int          r;

    model_reset();
    // Reset state
    #2;
    chk("rst_hrdata", out_sl_HRDATA, 32'h0);
    chk("rst_irq", frame_irq, 1'b0);
    chk("hready", out_sl_HREADY, 1'b1);
    chk("hresp", out_sl_HRESP, 2'b00);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    rd(4'd1, d); chk("t1_status", d, 32'h4);
    rd(4'd2, d); chk("t1_expect", d, 32'd196608);
    rd(4'd3, d); chk("t1_beatcnt", d, 32'h0);
    rd(4'd4, d); chk("t1_checksum", d, 32'h0);

    // Single beat round trip
    wr(4'd0, 32'h1);
    idle(1, 48'h112233445566);
    rd(4'd3, d); chk("t2_beatcnt", d, 32'h1);
    rd(4'd4, d); chk("t2_checksum", d, 32'h165);
    rd(4'd5, d); chk("t2_pix0", d, 32'h112233);
    rd(4'd6, d); chk("t2_pix1", d, 32'h445566);
    rd(4'd1, d); chk("t2_status", d, 32'h4);

    // Frame completion with interrupt
    wr(4'd2, 32'd4);
    wr(4'd0, 32'h7);
    for (int i = 0; i < 6; i++) begin
      idle(1, rnd_beat());
      #1;
      chk($sformatf("t3_irq%0d", i), frame_irq, (i >= 3) ? 1'b1 : 1'b0);
    end
    rd(4'd3, d); chk("t3_beatcnt", d, 32'd4);
    rd(4'd1, d); chk("t3_status", d, 32'h401);

    // Overflow after 20 beats, no reads
    wr(4'd2, 32'd0);
    wr(4'd0, 32'h3);
    b0 = rnd_beat();
    idle(1, b0);
    for (int i = 1; i < 20; i++) idle(1, rnd_beat());
    rd(4'd1, d); chk("t4_status", d, 32'h100A);
    rd(4'd3, d); chk("t4_beatcnt", d, 32'd20);
    rd(4'd5, d); chk("t4_pix0", d, {8'h0, b0[47:24]});

    // Full FIFO, beat coinciding with a pop
    wr(4'd0, 32'h3);
    for (int i = 0; i < 16; i++) idle(1, rnd_beat());
    rd(4'd1, d); chk("t5_full", d, 32'h1008);
    nb = rnd_beat();
    rd(4'd6, d, 1, nb);
    rd(4'd1, d); chk("t5_status", d, 32'h1008);
    for (int i = 0; i < 16; i++) rd(4'd6, d);
    chk("t5_tail", d, {8'h0, nb[23:0]});
    rd(4'd1, d); chk("t5_drained", d, 32'h4);

    // Clear coincident with a beat
    for (int i = 0; i < 3; i++) idle(1, rnd_beat());
    wr(4'd0, 32'h3, 1, rnd_beat());
    rd(4'd3, d); chk("t6_beatcnt", d, 32'h0);
    rd(4'd4, d); chk("t6_checksum", d, 32'h0);
    rd(4'd1, d); chk("t6_status", d, 32'h4);
    rd(4'd0, d); chk("t6_ctrl", d, 32'h1);

    // Randomized pipelined traffic
    for (int n = 0; n < 1000; n++) begin
      av  = ($urandom_range(0, 3) != 0);
      tr  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      r   = $urandom_range(0, 9);
      aidx = (r < 4) ? 4'd6 : (r == 4) ? 4'd0 : (r == 5) ? 4'd2 : 4'($urandom_range(0, 15));
      awr = ($urandom_range(0, 3) == 0);
      wd  = $urandom();
      if (m_di == 4'd0) begin
        wd[0] = ($urandom_range(0, 7) != 0);
        wd[1] = ($urandom_range(0, 1) == 0);
      end else if (m_di == 4'd2) begin
        wd = $urandom_range(0, 40);
      end
      bv = ($urandom_range(0, 2) != 0);
      cycle(av, tr, aidx, awr, wd, bv, rnd_beat(), d);
    end

    // Asynchronous reset in the middle of a frame
    wr(4'd2, 32'd2);
    wr(4'd0, 32'h7);
    for (int i = 0; i < 3; i++) idle(1, rnd_beat());
    @(negedge HCLK);
    chk("ar_irq_before", frame_irq, 1'b1);
    in_valid = 1'b1;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("ar_irq", frame_irq, 1'b0);
    chk("ar_hrdata", out_sl_HRDATA, 32'h0);
    model_reset();
    @(negedge HCLK);
    in_valid = 1'b0;
    sl_HSEL  = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd(4'd1, d); chk("ar_status", d, 32'h4);
    rd(4'd3, d); chk("ar_beatcnt", d, 32'h0);
    rd(4'd2, d); chk("ar_expect", d, 32'd196608);
    rd(4'd0, d); chk("ar_ctrl", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
